// File: rtl/conv2d_pkg.sv
// Shared types for the conv2d frame sequencer: FSM states and the sideband tag
// that travels alongside each pixel through the conv2d core latency.
package conv2d_pkg;

    localparam int unsigned KERNEL_SIZE_DEF = 3;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } state_e;

    typedef struct packed {
        logic tag_valid;
        logic win_ok;
        logic last;
    } sideband_t;

endpackage

// File: rtl/conv2d_tag_pipe.sv
// Fixed-depth shift register of sideband tags; shifts every clock, synchronous clear.
module conv2d_tag_pipe
    import conv2d_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic      clk,
    input  logic      clr,
    input  sideband_t din,
    output sideband_t head
);

    sideband_t stage_q [DEPTH];

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= din;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign head = stage_q[DEPTH-1];

endmodule

// File: rtl/conv2d_frame_ctrl.sv
// Frame sequencer feeding the streaming 3x3 conv2d core and filtering its results.
// Define CONV2D_FRAME_CTRL_STATS_EN to add the stall_cnt / drop_cnt statistics outputs.
module conv2d_frame_ctrl
    import conv2d_pkg::*;
#(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned GAIN_W      = 4,
    parameter int unsigned IMG_WIDTH   = 64,
    parameter int unsigned MAX_H_W     = 12,
    parameter int unsigned KERNEL_SIZE = KERNEL_SIZE_DEF,
    parameter int unsigned CONV_LAT    = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [MAX_H_W-1:0]       img_height,
    input  logic                     src_valid,
    input  logic [DATA_W-1:0]        src_pixel,
    output logic                     src_ready,
    output logic                     conv_valid_in,
    output logic [DATA_W-1:0]        conv_pixel_in,
    input  logic                     conv_valid_out,
    input  logic [DATA_W+GAIN_W-1:0] conv_pixel_out,
    output logic                     out_valid,
    output logic [DATA_W+GAIN_W-1:0] out_pixel,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done
`ifdef CONV2D_FRAME_CTRL_STATS_EN
    ,
    output logic [15:0]              stall_cnt,
    output logic [15:0]              drop_cnt
`endif
);

    localparam int unsigned COL_W = $clog2(IMG_WIDTH);
    localparam int unsigned DRN_W = $clog2(CONV_LAT) + 1;

    localparam logic [COL_W-1:0]   COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [COL_W-1:0]   COL_MIN  = COL_W'(KERNEL_SIZE - 1);
    localparam logic [MAX_H_W-1:0] ROW_MIN  = MAX_H_W'(KERNEL_SIZE - 1);
    localparam logic [MAX_H_W-1:0] H_MIN    = MAX_H_W'(KERNEL_SIZE);
    localparam logic [DRN_W-1:0]   DRN_LAST = DRN_W'(CONV_LAT - 1);

    state_e             state_q, state_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [MAX_H_W-1:0] row_q, row_d;
    logic [MAX_H_W-1:0] height_q, height_d;
    logic [DRN_W-1:0]   drn_q, drn_d;
    logic               cvi_q;
    logic [DATA_W-1:0]  cpi_q;
    sideband_t          tag_in_q, tag_in_d, pipe_head;
    logic               start_ok, xfer, last_px;

    assign start_ok = (state_q == StIdle) && start && (img_height >= H_MIN);
    assign xfer     = src_valid && (state_q == StRun);
    assign last_px  = (col_q == COL_LAST) && (row_q == height_q - MAX_H_W'(1));

    assign tag_in_d = '{tag_valid: xfer,
                        win_ok:    xfer && (row_q >= ROW_MIN) && (col_q >= COL_MIN),
                        last:      xfer && last_px};

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        height_d = height_q;
        drn_d    = drn_q;
        unique case (state_q)
            StIdle: begin
                if (start_ok) begin
                    state_d  = StRun;
                    height_d = img_height;
                    col_d    = '0;
                    row_d    = '0;
                end
            end
            StRun: begin
                if (xfer) begin
                    if (last_px) begin
                        state_d = StDrain;
                        drn_d   = '0;
                        col_d   = '0;
                        row_d   = '0;
                    end else if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = row_q + MAX_H_W'(1);
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end
            StDrain: begin
                if (drn_q == DRN_LAST) begin
                    state_d = StDone;
                end else begin
                    drn_d = drn_q + DRN_W'(1);
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= StIdle;
            col_q    <= '0;
            row_q    <= '0;
            height_q <= '0;
            drn_q    <= '0;
            cvi_q    <= 1'b0;
            cpi_q    <= '0;
            tag_in_q <= '0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            row_q    <= row_d;
            height_q <= height_d;
            drn_q    <= drn_d;
            cvi_q    <= xfer;
            tag_in_q <= tag_in_d;
            if (xfer) begin
                cpi_q <= src_pixel;
            end
        end
    end

    // Tag is registered alongside conv_valid_in, so the pipe head lines up with valid_out.
    conv2d_tag_pipe #(
        .DEPTH (CONV_LAT)
    ) u_tag_pipe (
        .clk  (clk),
        .clr  (!rst),
        .din  (tag_in_q),
        .head (pipe_head)
    );

    assign src_ready     = (state_q == StRun);
    assign busy          = (state_q == StRun) || (state_q == StDrain);
    assign done          = (state_q == StDone);
    assign conv_valid_in = cvi_q;
    assign conv_pixel_in = cpi_q;
    assign out_valid     = conv_valid_out && pipe_head.tag_valid && pipe_head.win_ok;
    assign out_pixel     = out_valid ? conv_pixel_out : '0;
    assign out_last      = out_valid && pipe_head.last;

`ifdef CONV2D_FRAME_CTRL_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst || start_ok) begin
            stall_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            if ((state_q == StRun) && !src_valid && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if ((conv_valid_out != pipe_head.tag_valid) && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_conv2d_frame_ctrl.sv
// Randomized bench for conv2d_frame_ctrl with a latency-2 conv2d stand-in and a
// frame-level reference model of which results must emerge.
module tb_conv2d_frame_ctrl;

    localparam int DW  = 8;
    localparam int GW  = 4;
    localparam int IW  = 64;
    localparam int HW  = 12;
    localparam int K   = 3;
    localparam int LAT = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            start = 1'b0;
    logic [HW-1:0]   img_height = '0;
    logic            src_valid = 1'b0;
    logic [DW-1:0]   src_pixel = '0;
    logic            src_ready;
    logic            conv_valid_in;
    logic [DW-1:0]   conv_pixel_in;
    logic            conv_valid_out;
    logic [DW+GW-1:0] conv_pixel_out;
    logic            out_valid;
    logic [DW+GW-1:0] out_pixel;
    logic            out_last;
    logic            busy;
    logic            done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    conv2d_frame_ctrl #(
        .DATA_W      (DW),
        .GAIN_W      (GW),
        .IMG_WIDTH   (IW),
        .MAX_H_W     (HW),
        .KERNEL_SIZE (K),
        .CONV_LAT    (LAT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .img_height     (img_height),
        .src_valid      (src_valid),
        .src_pixel      (src_pixel),
        .src_ready      (src_ready),
        .conv_valid_in  (conv_valid_in),
        .conv_pixel_in  (conv_pixel_in),
        .conv_valid_out (conv_valid_out),
        .conv_pixel_out (conv_pixel_out),
        .out_valid      (out_valid),
        .out_pixel      (out_pixel),
        .out_last       (out_last),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW+GW-1:0] conv_f(input logic [DW-1:0] p);
        return (DW+GW)'(p) * 12'd13 + 12'd7;
    endfunction

    // Stand-in conv2d core: fixed two-clock latency, arbitrary pixel transform.
    logic            mv0 = 1'b0, mv1 = 1'b0;
    logic [DW+GW-1:0] mp0 = '0, mp1 = '0;
    always @(posedge clk) begin
        mv0 <= conv_valid_in;
        mv1 <= mv0;
        mp0 <= conv_f(conv_pixel_in);
        mp1 <= mp0;
    end
    assign conv_valid_out = mv1;
    assign conv_pixel_out = mp1;

    // Monitor: append-only logs, sampled away from the rising edge.
    logic [DW-1:0]    sent_q[$];
    int               sent_cyc[$];
    logic [DW-1:0]    cin_q[$];
    int               cin_cyc[$];
    logic [DW+GW-1:0] res_q[$];
    bit               last_q[$];
    int               done_cyc[$];
    int rdy_cnt = 0, busy_cnt = 0, junk_cnt = 0;

    always @(negedge clk) begin
        if (src_valid && src_ready) begin
            sent_q.push_back(src_pixel);
            sent_cyc.push_back(cyc);
        end
        if (conv_valid_in) begin
            cin_q.push_back(conv_pixel_in);
            cin_cyc.push_back(cyc);
        end
        if (out_valid) begin
            res_q.push_back(out_pixel);
            last_q.push_back(out_last);
        end else if (out_pixel != '0 || out_last) begin
            junk_cnt++;
        end
        if (done) done_cyc.push_back(cyc);
        if (src_ready) rdy_cnt++;
        if (busy) busy_cnt++;
    end

    int b_sent, b_cin, b_res, b_done, b_rdy, b_busy;

    task automatic mark();
        b_sent = sent_q.size();
        b_cin  = cin_q.size();
        b_res  = res_q.size();
        b_done = done_cyc.size();
        b_rdy  = rdy_cnt;
        b_busy = busy_cnt;
    endtask

    // conv input stream must replay accepted pixels one clock later, bubbles included.
    function automatic int cin_errs();
        int n = sent_q.size() - b_sent;
        int e = 0;
        if (cin_q.size() - b_cin != n) e++;
        for (int i = 0; i < n && b_cin + i < cin_q.size(); i++) begin
            if (cin_q[b_cin+i] !== sent_q[b_sent+i]) e++;
            if (cin_cyc[b_cin+i] != sent_cyc[b_sent+i] + 1) e++;
        end
        return e;
    endfunction

    // Reference: every accepted pixel at row>=K-1, col>=K-1, in raster order; last flags final.
    function automatic int res_errs();
        logic [DW+GW-1:0] exp_p[$];
        int n = sent_q.size() - b_sent;
        int e = 0;
        int got;
        for (int i = 0; i < n; i++) begin
            if ((i / IW) >= K - 1 && (i % IW) >= K - 1) exp_p.push_back(conv_f(sent_q[b_sent+i]));
        end
        got = res_q.size() - b_res;
        if (got != exp_p.size()) e++;
        for (int j = 0; j < got && j < exp_p.size(); j++) begin
            if (res_q[b_res+j] !== exp_p[j]) e++;
            if (last_q[b_res+j] != (j == exp_p.size() - 1)) e++;
        end
        return e;
    endfunction

    function automatic int n_last();
        int c = 0;
        for (int j = b_res; j < last_q.size(); j++) if (last_q[j]) c++;
        return c;
    endfunction

    function automatic int done_gap();
        if (done_cyc.size() <= b_done || cin_cyc.size() <= b_cin) return -1;
        return done_cyc[b_done] - cin_cyc[cin_cyc.size()-1];
    endfunction

    // mode: 0 always valid, 1 toggling, 2 random. stop>0 returns once that many pixels moved.
    task automatic drive_frame(input int h, input int mode, input bit extra, input int stop,
                               output bit to);
        to = 1'b1;
        @(posedge clk); #1;
        start = 1'b1; img_height = HW'(h); src_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 0; n < h * IW * 4 + 100; n++) begin
            case (mode)
                0:       src_valid = 1'b1;
                1:       src_valid = (n % 2 == 0);
                default: src_valid = ($urandom_range(0, 3) != 0);
            endcase
            src_pixel = DW'($urandom);
            if (extra && (n % 29 == 7) && (sent_q.size() - b_sent < h * IW - 8)) begin
                start = 1'b1;
                img_height = HW'(K);
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (stop > 0 && sent_q.size() - b_sent >= stop) begin
                to = 1'b0;
                return;
            end
            if (done_cyc.size() > b_done) begin
                to = 1'b0;
                break;
            end
        end
        src_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        rst = 1'b0; src_valid = 1'b1; start = 1'b1; img_height = HW'(64);
        repeat (3) begin
            @(negedge clk);
            total++;
            if ({src_ready, conv_valid_in, out_valid, out_last, busy, done} !== 6'b0 ||
                out_pixel !== '0) begin
                bad++;
                $display("FAIL reset_outputs: got ready=%b cvi=%b ov=%b last=%b busy=%b done=%b pix=%h, want all 0",
                         src_ready, conv_valid_in, out_valid, out_last, busy, done, out_pixel);
            end
        end
        @(posedge clk); #1;
        src_valid = 1'b0; start = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_full_frame();
        bit to;
        int e;
        mark();
        drive_frame(64, 0, 1'b0, 0, to);
        total++; if (to) begin bad++; $display("FAIL full_timeout: got no done, want done"); end
        total++;
        if (sent_q.size() - b_sent != 4096) begin
            bad++; $display("FAIL full_transfers: got %0d want 4096", sent_q.size() - b_sent);
        end
        total++; e = cin_errs();
        if (e != 0) begin bad++; $display("FAIL full_conv_in: got %0d errors want 0", e); end
        total++;
        if (res_q.size() - b_res != 3844) begin
            bad++; $display("FAIL full_results: got %0d want 3844", res_q.size() - b_res);
        end
        total++; e = res_errs();
        if (e != 0) begin bad++; $display("FAIL full_result_data: got %0d errors want 0", e); end
        total++;
        if (n_last() != 1) begin bad++; $display("FAIL full_last_count: got %0d want 1", n_last()); end
        total++;
        if (done_cyc.size() - b_done != 1) begin
            bad++; $display("FAIL full_done_count: got %0d want 1", done_cyc.size() - b_done);
        end
        total++;
        if (done_gap() != LAT) begin
            bad++; $display("FAIL full_done_timing: got gap %0d want %0d", done_gap(), LAT);
        end
    endtask

    task automatic test_stalls();
        bit to;
        int e;
        mark();
        drive_frame(4, 1, 1'b0, 0, to);
        total++; if (to) begin bad++; $display("FAIL stall_timeout: got no done, want done"); end
        total++; e = cin_errs();
        if (e != 0) begin bad++; $display("FAIL stall_bubbles: got %0d errors want 0", e); end
        total++;
        if (res_q.size() - b_res != 124) begin
            bad++; $display("FAIL stall_results: got %0d want 124", res_q.size() - b_res);
        end
        total++; e = res_errs();
        if (e != 0) begin bad++; $display("FAIL stall_result_data: got %0d errors want 0", e); end
        total++;
        if (done_gap() != LAT) begin
            bad++; $display("FAIL stall_done_timing: got gap %0d want %0d", done_gap(), LAT);
        end
    endtask

    task automatic test_random_stalls();
        bit to;
        int e;
        int h = $urandom_range(K, 7);
        mark();
        drive_frame(h, 2, 1'b0, 0, to);
        total++; if (to) begin bad++; $display("FAIL rand_timeout: got no done, want done"); end
        total++; e = cin_errs();
        if (e != 0) begin bad++; $display("FAIL rand_conv_in: got %0d errors want 0", e); end
        total++;
        if (res_q.size() - b_res != (IW - K + 1) * (h - K + 1)) begin
            bad++; $display("FAIL rand_results: got %0d want %0d", res_q.size() - b_res,
                            (IW - K + 1) * (h - K + 1));
        end
        total++; e = res_errs();
        if (e != 0) begin bad++; $display("FAIL rand_result_data: got %0d errors want 0", e); end
    endtask

    task automatic test_bad_height();
        int h = $urandom_range(0, K - 1);
        mark();
        @(posedge clk); #1;
        start = 1'b1; img_height = HW'(h); src_valid = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) begin @(posedge clk); #1; end
        src_valid = 1'b0;
        total++;
        if (rdy_cnt - b_rdy != 0 || busy_cnt - b_busy != 0) begin
            bad++; $display("FAIL bad_height_idle: got ready=%0d busy=%0d cycles want 0 (h=%0d)",
                            rdy_cnt - b_rdy, busy_cnt - b_busy, h);
        end
        total++;
        if (done_cyc.size() - b_done != 0 || sent_q.size() - b_sent != 0) begin
            bad++; $display("FAIL bad_height_done: got done=%0d xfers=%0d want 0",
                            done_cyc.size() - b_done, sent_q.size() - b_sent);
        end
    endtask

    task automatic test_mid_reset();
        bit to;
        int e;
        mark();
        drive_frame(64, 2, 1'b0, 10 * IW, to);
        total++; if (to) begin bad++; $display("FAIL midrst_reach: got timeout want row 10"); end
        rst = 1'b0; src_valid = 1'b1;
        @(posedge clk); #1;
        mark();
        @(negedge clk);
        total++;
        if ({busy, src_ready, conv_valid_in, out_valid, done} !== 5'b0) begin
            bad++; $display("FAIL midrst_idle: got busy=%b ready=%b cvi=%b ov=%b done=%b want 0",
                            busy, src_ready, conv_valid_in, out_valid, done);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (8) begin @(posedge clk); #1; end
        src_valid = 1'b0;
        total++;
        if (done_cyc.size() - b_done != 0 || res_q.size() - b_res != 0 || rdy_cnt - b_rdy != 0) begin
            bad++; $display("FAIL midrst_quiet: got done=%0d results=%0d ready=%0d want 0",
                            done_cyc.size() - b_done, res_q.size() - b_res, rdy_cnt - b_rdy);
        end
        mark();
        drive_frame(3, 0, 1'b0, 0, to);
        total++; if (to) begin bad++; $display("FAIL midrst_restart: got no done, want done"); end
        total++;
        if (res_q.size() - b_res != 62) begin
            bad++; $display("FAIL midrst_results: got %0d want 62", res_q.size() - b_res);
        end
        total++; e = res_errs();
        if (e != 0) begin bad++; $display("FAIL midrst_result_data: got %0d errors want 0", e); end
        total++;
        if (done_cyc.size() - b_done != 1) begin
            bad++; $display("FAIL midrst_done: got %0d want 1", done_cyc.size() - b_done);
        end
    endtask

    task automatic test_start_during_run();
        bit to;
        int e;
        int h = $urandom_range(5, 8);
        mark();
        drive_frame(h, 2, 1'b1, 0, to);
        total++; if (to) begin bad++; $display("FAIL restart_timeout: got no done, want done"); end
        total++;
        if (sent_q.size() - b_sent != h * IW) begin
            bad++; $display("FAIL restart_transfers: got %0d want %0d", sent_q.size() - b_sent, h * IW);
        end
        total++;
        if (res_q.size() - b_res != (IW - K + 1) * (h - K + 1)) begin
            bad++; $display("FAIL restart_results: got %0d want %0d", res_q.size() - b_res,
                            (IW - K + 1) * (h - K + 1));
        end
        total++; e = res_errs();
        if (e != 0) begin bad++; $display("FAIL restart_result_data: got %0d errors want 0", e); end
        total++;
        if (done_cyc.size() - b_done != 1) begin
            bad++; $display("FAIL restart_done: got %0d want 1", done_cyc.size() - b_done);
        end
    endtask

    task automatic test_idle_outputs();
        total++;
        if (junk_cnt != 0) begin
            bad++; $display("FAIL idle_out_zero: got %0d non-zero idle cycles want 0", junk_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_stalls();
        test_random_stalls();
        test_bad_height();
        test_mid_reset();
        test_start_during_run();
        test_idle_outputs();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
